// File: rtl/grp_wr_arbiter.sv
// Group-buffer write arbiter: round-robin ownership of the write path with bank-switch preemption.
// Optional hold watchdog is compiled in with GRP_ARB_TIMEOUT_EN.
module grp_wr_arbiter #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 1024,
    parameter int GUARD    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             swch_async,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       owner,
    output logic             busy,
    output logic             bank_sel,
    output logic [N_REQ-1:0] preempt,
    output logic [7:0]       timeout_cnt,
    output logic [1:0]       dbg_state
);

    // Handshake: req is a level held by a writer; grant is registered one-hot ownership that
    // stays up until the owner pulses done for one cycle (or it is preempted), after which
    // grant is low for at least one cycle before the next owner is granted.

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2 || GUARD < 1) begin : g_bad_cfg
        $error("grp_wr_arbiter: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] preempt_q, preempt_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       last_owner_q, last_owner_d;
    logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
    logic             arm_q;
    logic             sync1_q, sync2_q, sync3_q;

    logic             switch_evt;
    logic             owner_done;
    logic             hold_expired;
    logic [7:0]       req_ext;
    logic [7:0]       done_ext;
    logic             rr_found;
    logic [2:0]       rr_idx;
    logic [3:0]       rr_sum;

    // Two-flop synchronizer plus a history flop; either edge of the bank level is an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= swch_async;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign switch_evt = sync2_q ^ sync3_q;
    assign req_ext    = 8'(req);
    assign done_ext   = 8'(done);
    assign owner_done = done_ext[owner_q];

    // Search starts one past the previous owner and wraps modulo N_REQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_sum = {1'b0, last_owner_q} + 4'(k);
            if (rr_sum >= 4'(N_REQ)) begin
                rr_sum = rr_sum - 4'(N_REQ);
            end
            if (!rr_found && req_ext[rr_sum[2:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[2:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        preempt_d    = '0;
        guard_cnt_d  = guard_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (switch_evt) begin
                    state_d     = S_GUARD;
                    guard_cnt_d = '0;
                end else if (arm_q && rr_found) begin
                    state_d      = S_GRANT;
                    grant_d      = N_REQ'(1) << rr_idx;
                    owner_d      = rr_idx;
                    last_owner_d = rr_idx;
                end
            end
            S_GRANT: begin
                // A done in the same cycle as a switch is an ordinary release.
                if (owner_done) begin
                    grant_d = '0;
                    if (switch_evt) begin
                        state_d     = S_GUARD;
                        guard_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (switch_evt || hold_expired) begin
                    grant_d     = '0;
                    preempt_d   = grant_q;
                    state_d     = S_GUARD;
                    guard_cnt_d = '0;
                end
            end
            S_GUARD: begin
                if (switch_evt) begin
                    guard_cnt_d = '0;
                end else if (guard_cnt_q == GW'(GUARD - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            preempt_q    <= '0;
            owner_q      <= '0;
            last_owner_q <= 3'(N_REQ - 1);
            guard_cnt_q  <= '0;
            arm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            preempt_q    <= preempt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            guard_cnt_q  <= guard_cnt_d;
            arm_q        <= 1'b1;
        end
    end

`ifdef GRP_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt_q;
    logic [7:0]    timeout_q;

    assign hold_expired = (state_q == S_GRANT) && (hold_cnt_q == HW'(MAX_HOLD - 1));

    // Held at zero outside GRANT so every new ownership starts a fresh count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            timeout_q  <= '0;
        end else begin
            hold_cnt_q <= (state_q == S_GRANT) ? hold_cnt_q + HW'(1) : '0;
            if (hold_expired && !owner_done && timeout_q != 8'hFF) begin
                timeout_q <= timeout_q + 8'd1;
            end
        end
    end

    assign timeout_cnt = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout_cnt  = 8'd0;
`endif

    assign grant     = grant_q;
    assign preempt   = preempt_q;
    assign owner     = owner_q;
    assign busy      = |grant_q;
    assign bank_sel  = sync3_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_grp_wr_arbiter.sv
// Bench for grp_wr_arbiter: directed scenarios plus randomized releases against a round-robin model.
module tb_grp_wr_arbiter;

    localparam int N        = 5;
    localparam int MAX_HOLD = 16;
    localparam int GUARD_C  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic         swch_async;
    logic [N-1:0] grant;
    logic [2:0]   owner;
    logic         busy;
    logic         bank_sel;
    logic [N-1:0] preempt;
    logic [7:0]   timeout_cnt;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    grp_wr_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD), .GUARD(GUARD_C)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .swch_async (swch_async),
        .grant      (grant),
        .owner      (owner),
        .busy       (busy),
        .bank_sel   (bank_sel),
        .preempt    (preempt),
        .timeout_cnt(timeout_cnt),
        .dbg_state  (dbg_state)
    );

    // Record: [11] preempt event, [10:8] writer index, [7:0] grant-low gap (FF = any).
    logic [11:0]  exp_q[$];
    logic [11:0]  e;
    int           n_vec = 0;
    int           n_err = 0;
    logic         mon_en = 1'b0;
    int           mon_owner = 0;
    int           low_cnt = 0;
    logic [N-1:0] prev_grant = '0;
    int           owner_m;
    logic         bank_exp;
    int           exp_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic push_grant(input int idx, input int gap);
        exp_q.push_back({1'b0, 3'(idx), (gap < 0) ? 8'hFF : 8'(gap)});
    endtask

    task automatic push_preempt(input int idx);
        exp_q.push_back({1'b1, 3'(idx), 8'h00});
    endtask

    // Monitor: pops one record per new grant or preempt pulse.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_grant = '0;
            low_cnt    = 0;
            mon_owner  = 0;
        end else begin
            check("busy", busy, grant != '0);
            if (preempt != '0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_preempt: got 0x%0h, required none", preempt);
                end else begin
                    e = exp_q.pop_front();
                    check("preempt_kind", e[11], 32'd1);
                    check("preempt_bit", preempt, 32'd1 << e[10:8]);
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_grant: got 0x%0h, required none", grant);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_kind", e[11], 32'd0);
                    check("grant_bit", grant, 32'd1 << e[10:8]);
                    check("owner", owner, e[10:8]);
                    if (e[7:0] != 8'hFF) check("grant_gap", low_cnt, e[7:0]);
                    mon_owner = e[10:8];
                end
                low_cnt = 0;
            end else if (grant != '0) begin
                check("grant_held", grant, 32'd1 << mon_owner);
            end else begin
                low_cnt++;
                check("owner_idle", owner, mon_owner);
            end
            prev_grant = grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int bound);
        int t;
        t = 0;
        while (grant == '0 && t < bound) begin
            tick();
            t++;
        end
        check("grant_arrives", grant != '0, 32'd1);
    endtask

    task automatic wait_release(input int bound);
        int t;
        t = 0;
        while (grant != '0 && t < bound) begin
            tick();
            t++;
        end
        check("grant_released", grant == '0, 32'd1);
    endtask

    task automatic hold_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            req  = N'($urandom);
            done = N'($urandom) & ~(N'(1) << owner_m);
            tick();
            done = '0;
        end
    endtask

    task automatic release_done(input logic [N-1:0] m, input logic [N-1:0] junk);
        req  = m;
        done = (N'(1) << owner_m) | junk;
        if (m != '0) begin
            owner_m = rr(owner_m, m);
            push_grant(owner_m, 1);
        end
        tick();
        done = '0;
        wait_release(4);
    endtask

    task automatic release_switch(input logic [N-1:0] m);
        int nxt;
        req        = m;
        swch_async = ~swch_async;
        bank_exp   = swch_async;
        push_preempt(owner_m);
        nxt = rr(owner_m, m);
        if (nxt >= 0) begin
            owner_m = nxt;
            push_grant(nxt, GUARD_C + 1);
        end
        wait_release(8);
        check("bank_sel", bank_sel, bank_exp);
    endtask

    task automatic release_both(input logic [N-1:0] m);
        req        = m;
        swch_async = ~swch_async;
        bank_exp   = swch_async;
        tick();
        tick();
        done = N'(1) << owner_m;
        owner_m = rr(owner_m, m);
        push_grant(owner_m, GUARD_C + 1);
        tick();
        done = '0;
        wait_release(4);
        check("bank_sel", bank_sel, bank_exp);
    endtask

    task automatic idle_switch(input logic [N-1:0] m);
        swch_async = ~swch_async;
        bank_exp   = swch_async;
        tick();
        tick();
        req = m;
        owner_m = rr(owner_m, m);
        push_grant(owner_m, -1);
        for (int c = 0; c < GUARD_C + 1; c++) begin
            tick();
            check("idle_switch_hold_off", grant, '0);
        end
        tick();
        check("idle_switch_grant", grant, N'(1) << owner_m);
        check("bank_sel", bank_sel, bank_exp);
    endtask

    task automatic check_reset_values();
        check("rst_grant", grant, '0);
        check("rst_preempt", preempt, '0);
        check("rst_busy", busy, '0);
        check("rst_owner", owner, '0);
        check("rst_bank_sel", bank_sel, '0);
        check("rst_timeout_cnt", timeout_cnt, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        req        = '0;
        done       = '0;
        swch_async = 1'b0;
        bank_exp   = 1'b0;
        owner_m    = N - 1;
        exp_to     = 0;
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        #3;
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();
        tick();

        // Writer 0 first, then writer 2 after a one-cycle gap.
        req = 5'b00101;
        owner_m = rr(owner_m, req);
        push_grant(owner_m, -1);
        tick();
        check("first_grant_latency", grant, 5'b00001);
        tick();
        release_done(5'b00101, '0);
        wait_grant(10);
        check("rr_second", grant, 5'b00100);

        // Asynchronous reset mid-grant.
        mon_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values();
        req        = 5'b10110;
        done       = '0;
        swch_async = 1'b0;
        bank_exp   = 1'b0;
        owner_m    = rr(N - 1, req);
        push_grant(owner_m, -1);
        tick();
        mon_en = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        check("reset_release_no_grant", grant, '0);
        tick();
        check("reset_first_grant", grant, 5'b00010);

        // Everyone requesting, done three cycles after each grant.
        for (int i = 0; i < 6; i++) begin
            wait_grant(10);
            tick();
            tick();
            release_done('1, '0);
        end

        // Writer 3 preempted by a bank switch while writer 4 waits.
        wait_grant(10);
        tick();
        release_done(5'b01000, '0);
        wait_grant(10);
        tick();
        tick();
        release_switch(5'b10000);

        // Writer 1 releases in the switch-event cycle.
        wait_grant(10);
        tick();
        release_done(5'b00010, '0);
        wait_grant(10);
        tick();
        release_both(5'b00101);

        // Switch while idle holds off a fresh request.
        wait_grant(10);
        tick();
        release_done('0, '0);
        tick();
        tick();
        idle_switch(5'b01001);

`ifdef GRP_ARB_TIMEOUT_EN
        check("timeout_cnt_before", timeout_cnt, 8'd0);
        req = 5'b00011;
        push_preempt(owner_m);
        owner_m = rr(owner_m, req);
        push_grant(owner_m, GUARD_C + 1);
        exp_to++;
        wait_release(MAX_HOLD + 10);
        check("timeout_cnt", timeout_cnt, 32'(exp_to));
`else
        repeat (1100) tick();
        check("long_hold", grant, N'(1) << owner_m);
        check("timeout_cnt_tied", timeout_cnt, 8'd0);
        release_done(5'b00011, '0);
`endif

        for (int it = 0; it < 150; it++) begin
            logic [N-1:0] m;
            int           act;
            wait_grant(12);
            hold_phase($urandom_range(1, 6));
            m   = N'($urandom_range(1, (1 << N) - 1));
            act = $urandom_range(0, 9);
            if (act < 7) release_done(m, N'($urandom));
            else if (act < 9) release_switch(m);
            else release_both(m);
        end

        wait_grant(12);
        release_done('0, '0);
        repeat (6) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
